ddr3_req_sequencer: RTL and testbench

- Request front-end that sits directly upstream of the DDR3 command state machine.
- Debounces the raw write/read push-buttons and generates periodic refresh requests.
- Arbitrates refresh, write and read, then issues one single-cycle command pulse at a time with a stable row/column/bank address.
- Uses the state machine's idle indication as the accept/complete handshake.

---
 rtl/ddr3_req_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ddr3_req_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_req_sequencer.sv
// Request front-end for the DDR3 command FSM: debounced write/read buttons, periodic
// refresh queue, fixed-priority arbitration and single-cycle command pulses.
module ddr3_req_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REFI_CYCLES     = 780,
  parameter int unsigned MAX_POSTPONE    = 8,
  parameter int unsigned ACK_TIMEOUT     = 16,
  parameter int unsigned COL_STEP        = 8,
  parameter logic [14:0] ROW_ADDR        = 15'd1,
  parameter logic [2:0]  BANK_ADDR       = 3'b101
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        btn_write,
  input  logic        btn_read,
  input  logic        sm_idle,
  output logic        WRITE,
  output logic        READ,
  output logic        REF,
  output logic [14:0] Addr_Row,
  output logic [9:0]  Addr_Column,
  output logic [2:0]  BA_out,
  output logic        busy,
  output logic        ref_overflow,
  output logic        err
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RFW = $clog2(REFI_CYCLES + 1);
  localparam int unsigned QW  = $clog2(MAX_POSTPONE + 1);
  localparam int unsigned AW  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {OP_REF, OP_WR, OP_RD} op_t;

  logic [1:0]     btn_raw, rise, pend_q, pend_d, clr;
  logic [RFW-1:0] refi_q, refi_d;
  logic           tick, ref_dec;
  logic [QW-1:0]  refq_q, refq_d;
  logic           ovf_q, ovf_d;
  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [9:0]     col_q, col_d, wcol_q, wcol_d, rcol_q, rcol_d;
  logic [AW-1:0]  ack_q, ack_d;
  logic           err_q, err_d;

  assign btn_raw = {btn_read, btn_write};

  // index 0 = write button, 1 = read button
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic           sync1_q, sync2_q, deb_q, deb_d;
    logic [DBW-1:0] cnt_q, cnt_d;

    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
        else                                    cnt_d = cnt_q + 1'b1;
      end
    end

    assign rise[g] = deb_d & ~deb_q;

    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[g];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  // a new press landing on the retire cycle wins over the clear
  assign pend_d = (pend_q & ~clr) | rise;

  always_comb begin
    tick   = (refi_q == RFW'(REFI_CYCLES - 1));
    refi_d = tick ? '0 : refi_q + 1'b1;
    refq_d = refq_q;
    ovf_d  = ovf_q;
    if (tick && !ref_dec) begin
      if (refq_q == QW'(MAX_POSTPONE)) ovf_d  = 1'b1;
      else                             refq_d = refq_q + 1'b1;
    end else if (!tick && ref_dec) begin
      refq_d = refq_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    col_d   = col_q;
    wcol_d  = wcol_q;
    rcol_d  = rcol_q;
    ack_d   = ack_q;
    err_d   = err_q;
    clr     = '0;
    ref_dec = 1'b0;
    case (state_q)
      S_INIT: if (sm_idle) state_d = S_IDLE;
      S_IDLE: begin
        if (sm_idle) begin
          if (refq_q != '0) begin
            op_d = OP_REF; col_d = '0; state_d = S_ISSUE;
          end else if (pend_q[0]) begin
            op_d = OP_WR; col_d = wcol_q; state_d = S_ISSUE;
          end else if (pend_q[1]) begin
            op_d = OP_RD; col_d = rcol_q; state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        ack_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!sm_idle) begin
          state_d = S_WAIT_DONE;
        end else if (ack_q == AW'(ACK_TIMEOUT - 1)) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (sm_idle) begin
          state_d = S_IDLE;
          case (op_q)
            OP_REF: ref_dec = 1'b1;
            OP_WR: begin
              clr[0] = 1'b1;
              wcol_d = wcol_q + 10'(COL_STEP);
            end
            OP_RD: begin
              clr[1] = 1'b1;
              rcol_d = rcol_q + 10'(COL_STEP);
            end
            default: ;
          endcase
        end
      end
      S_ERROR: ;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pend_q  <= '0;
      refi_q  <= '0;
      refq_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_INIT;
      op_q    <= OP_REF;
      col_q   <= '0;
      wcol_q  <= '0;
      rcol_q  <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      refi_q  <= refi_d;
      refq_q  <= refq_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      op_q    <= op_d;
      col_q   <= col_d;
      wcol_q  <= wcol_d;
      rcol_q  <= rcol_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign WRITE        = (state_q == S_ISSUE) && (op_q == OP_WR);
  assign READ         = (state_q == S_ISSUE) && (op_q == OP_RD);
  assign REF          = (state_q == S_ISSUE) && (op_q == OP_REF);
  assign busy         = (state_q != S_INIT) && (state_q != S_IDLE);
  assign Addr_Row     = ROW_ADDR;
  assign BA_out       = BANK_ADDR;
  assign Addr_Column  = col_q;
  assign ref_overflow = ovf_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ddr3_req_sequencer.sv
// Bench for ddr3_req_sequencer: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized button/ack traffic.
module tb_ddr3_req_sequencer;

  localparam int DEB  = 4;
  localparam int REFI = 50;
  localparam int ACKT = 4;
  localparam int MAXP = 8;
  localparam int STEP = 8;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        btn_write = 1'b0;
  logic        btn_read = 1'b0;
  logic        sm_idle;
  logic        WRITE, READ, REF, busy, ref_overflow, err;
  logic [14:0] Addr_Row;
  logic [9:0]  Addr_Column;
  logic [2:0]  BA_out;

  ddr3_req_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .REFI_CYCLES(REFI),
    .MAX_POSTPONE(MAXP),
    .ACK_TIMEOUT(ACKT),
    .COL_STEP(STEP)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .btn_write(btn_write), .btn_read(btn_read),
    .sm_idle(sm_idle), .WRITE(WRITE), .READ(READ), .REF(REF),
    .Addr_Row(Addr_Row), .Addr_Column(Addr_Column), .BA_out(BA_out),
    .busy(busy), .ref_overflow(ref_overflow), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // op codes: 1 = REF, 2 = WRITE, 3 = READ
  bit m_valid = 0;
  int m_d1[2], m_d2[2], m_sprev[2], m_run[2], m_deb[2], m_pend[2];
  int m_n, m_refq, m_ovf, m_err, m_wcol, m_rcol, m_col;
  int m_up, m_op, m_age, m_acked, m_idle_run, m_dead;

  always @(posedge CLK) begin : model
    int raw[2];
    int rise[2];
    int clr[2];
    int s, tick, dec, idle;
    idle = int'(sm_idle);
    raw[0] = int'(btn_write);
    raw[1] = int'(btn_read);
    if (!RESET_N) begin
      m_valid = 1;
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_sprev[b] = 0; m_run[b] = 0; m_deb[b] = 0; m_pend[b] = 0;
      end
      m_n = 0; m_refq = 0; m_ovf = 0; m_err = 0; m_wcol = 0; m_rcol = 0; m_col = 0;
      m_up = 0; m_op = 0; m_age = 0; m_acked = 0; m_idle_run = 0; m_dead = 0;
    end else begin
      // button level accepted once the synchronized value has stayed put DEB samples
      for (int b = 0; b < 2; b++) begin
        s = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
        m_run[b] = (s == m_sprev[b]) ? m_run[b] + 1 : 1;
        m_sprev[b] = s;
        rise[b] = 0;
        clr[b] = 0;
        if (s != m_deb[b] && m_run[b] >= DEB) begin
          m_deb[b] = s;
          rise[b] = s;
        end
      end
      tick = ((m_n % REFI) == REFI - 1) ? 1 : 0;
      m_n++;
      dec = 0;
      if (!m_up) begin
        if (idle) m_up = 1;
      end else if (m_dead) begin
      end else if (m_op == 0) begin
        if (idle) begin
          if (m_refq > 0)   begin m_op = 1; m_col = 0; end
          else if (m_pend[0]) begin m_op = 2; m_col = m_wcol; end
          else if (m_pend[1]) begin m_op = 3; m_col = m_rcol; end
          m_age = 1; m_acked = 0; m_idle_run = 0;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (!m_acked) begin
        if (!idle) m_acked = 1;
        else begin
          m_idle_run++;
          if (m_idle_run == ACKT) begin m_dead = 1; m_err = 1; end
        end
      end else if (idle) begin
        if (m_op == 1) dec = 1;
        if (m_op == 2) begin clr[0] = 1; m_wcol = (m_wcol + STEP) % 1024; end
        if (m_op == 3) begin clr[1] = 1; m_rcol = (m_rcol + STEP) % 1024; end
        m_op = 0;
      end
      if (tick && !dec) begin
        if (m_refq == MAXP) m_ovf = 1; else m_refq++;
      end else if (!tick && dec) begin
        m_refq--;
      end
      for (int b = 0; b < 2; b++) m_pend[b] = ((m_pend[b] && !clr[b]) || rise[b]) ? 1 : 0;
    end
  end

  always @(negedge CLK) begin : compare
    logic [33:0] act, exp;
    logic pulse;
    if (m_valid) begin
      pulse = (m_op != 0) && (m_age == 1) && !m_dead;
      act = {WRITE, READ, REF, busy, ref_overflow, err, Addr_Column, Addr_Row, BA_out};
      exp = {pulse && m_op == 2, pulse && m_op == 3, pulse && m_op == 1,
             1'(m_up != 0 && m_op != 0), 1'(m_ovf), 1'(m_err), 10'(m_col), 15'd1, 3'b101};
      check("cycle_outputs", {30'd0, act}, {30'd0, exp});
    end
  end

  // ---------------- pulse log ----------------
  int plog[$];
  int pcol[$];
  int n_wr = 0;

  always @(negedge CLK) begin
    if (RESET_N && (WRITE || READ || REF)) begin
      plog.push_back(WRITE ? 2 : (READ ? 3 : 1));
      pcol.push_back(int'(Addr_Column));
      if (WRITE) n_wr++;
      check("pulse_row_bank", {46'd0, Addr_Row, BA_out}, {46'd0, 15'd1, 3'b101});
    end
  end

  function automatic int cnt_op(input int base, input int code);
    int c = 0;
    for (int i = base; i < plog.size(); i++) if (plog[i] == code) c++;
    return c;
  endfunction

  function automatic int nth_col(input int base, input int code, input int n);
    int c = 0;
    for (int i = base; i < plog.size(); i++)
      if (plog[i] == code) begin
        if (c == n) return pcol[i];
        c++;
      end
    return -1;
  endfunction

  function automatic int op_at(input int idx);
    return (idx < plog.size()) ? plog[idx] : -1;
  endfunction

  // ---------------- sm_idle responder ----------------
  // mode 0: drop idle for rsp_k cycles after each pulse; 1: hold low; 2: never acknowledge
  int rsp_mode = 0;
  int rsp_k = 5;
  int rsp_left = 0;

  initial begin
    sm_idle = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (rsp_mode == 1) begin
        sm_idle = 1'b0; rsp_left = 0;
      end else if (rsp_mode == 2) begin
        sm_idle = 1'b1;
      end else if (WRITE || READ || REF) begin
        sm_idle = 1'b0; rsp_left = rsp_k - 1;
      end else if (rsp_left > 0) begin
        sm_idle = 1'b0; rsp_left--;
      end else begin
        sm_idle = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset(input int n);
    RESET_N = 1'b0; btn_write = 1'b0; btn_read = 1'b0;
    cyc(n);
    check("reset_values",
          {30'd0, WRITE, READ, REF, busy, ref_overflow, err, Addr_Column, Addr_Row, BA_out},
          {30'd0, 6'b0, 10'd0, 15'd1, 3'b101});
    RESET_N = 1'b1;
  endtask

  task automatic press(input bit wr, input bit rd, input int hold);
    btn_write = wr; btn_read = rd;
    cyc(hold);
    btn_write = 1'b0; btn_read = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, t, seen;

    // bouncing write press, then a clean press
    rsp_mode = 0; rsp_k = 5;
    do_reset(3);
    base = plog.size();
    for (int i = 0; i < 5; i++) begin btn_write = (i % 2 == 0); cyc(2); end
    btn_write = 1'b1; cyc(20);
    btn_write = 1'b0; cyc(20);
    check("bounce_single_write", cnt_op(base, 2), 1);
    check("bounce_write_col", nth_col(base, 2, 0), 0);
    press(1, 0, 8); cyc(30);
    check("second_write_count", cnt_op(base, 2), 2);
    check("second_write_col", nth_col(base, 2, 1), 8);

    // simultaneous presses racing a refresh tick
    do_reset(2);
    base = plog.size();
    cyc(45);
    press(1, 1, 10);
    cyc(60);
    check("order_first_ref", op_at(base), 1);
    check("order_second_write", op_at(base + 1), 2);
    check("order_third_read", op_at(base + 2), 3);

    // refresh queue saturation while the command FSM is held busy
    rsp_mode = 1;
    do_reset(2);
    cyc(500);
    check("saturate_overflow", ref_overflow, 1);
    base = plog.size();
    rsp_k = 2; rsp_mode = 0;
    cyc(45);
    check("saturate_ref_count", cnt_op(base, 1), 8);
    check("saturate_only_refs", plog.size() - base, 8);

    // acknowledge timeout
    rsp_mode = 2;
    do_reset(2);
    base = plog.size();
    press(0, 1, 6);
    cyc(14);
    check("timeout_err", err, 1);
    check("timeout_first_read", op_at(base), 3);
    press(1, 0, 6);
    cyc(80);
    check("timeout_no_more_pulses", plog.size() - base, 1);

    // column walk and wrap over 129 writes
    rsp_mode = 0;
    do_reset(2);
    base = plog.size();
    seen = n_wr;
    for (int i = 0; i < 129; i++) begin
      rsp_k = $urandom_range(2, 6);
      press(1, 0, 6);
      t = 0;
      while (n_wr < seen + i + 1 && t < 300) begin cyc(1); t++; end
      check("walk_write_seen", n_wr - seen, i + 1);
      cyc(12);
    end
    for (int i = 0; i < 129; i++) check("walk_col", nth_col(base, 2, i), (i * STEP) % 1024);
    check("walk_col_128th", nth_col(base, 2, 127), 1016);
    check("walk_col_wrap", nth_col(base, 2, 128), 0);

    // reset while a write waits for completion, with read and refresh pending
    rsp_k = 5;
    do_reset(2);
    press(1, 0, 6);
    t = 0;
    while (!WRITE && t < 100) begin cyc(1); t++; end
    check("midreset_write_seen", WRITE, 1);
    rsp_mode = 1;
    press(0, 1, 6);
    cyc(60);
    check("midreset_busy_before", busy, 1);
    rsp_mode = 1;
    do_reset(2);
    base = plog.size();
    cyc(10);
    check("midreset_init_holds", busy, 0);
    rsp_mode = 0;
    cyc(25);
    check("midreset_no_stale", plog.size() - base, 0);
    cyc(30);
    check("midreset_fresh_ref", cnt_op(base, 1), 1);
    check("midreset_only_ref", plog.size() - base, 1);

    // randomized buttons and acknowledge latency
    do_reset(2);
    for (int it = 0; it < 150; it++) begin
      int dur;
      dur = $urandom_range(1, 12);
      btn_write = 1'($urandom_range(0, 1));
      btn_read = 1'($urandom_range(0, 1));
      rsp_k = $urandom_range(2, 6);
      rsp_mode = ($urandom_range(0, 19) == 0) ? 1 : 0;
      cyc(dur);
    end
    rsp_mode = 0; btn_write = 1'b0; btn_read = 1'b0;
    cyc(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
